mix_train_sched: RTL and testbench

//  Training-step sequencer for mix_block. It drives run_forward, run_backward,

---
 rtl/mix_train_sched_pkg.sv | 33 +++
 rtl/mix_train_sched_watchdog.sv | 40 ++++
 rtl/mix_train_sched.sv | 190 +++++++++++++++++++
 tb/tb_mix_train_sched.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_train_sched_pkg.sv
// -----------------------------------------------------------------------------
// mix_train_sched_pkg
//   Shared constants for the mix_block training sequencer: width and encodings
//   of the layer selectors driven to mix_block, and the sequencer FSM states.
//   Forward and backward selectors share one encoding (index of the MIX layer
//   minus one), so a phase counter can drive either selector directly.
// -----------------------------------------------------------------------------
package mix_train_sched_pkg;

  localparam int STATE_LEN = 2;

  localparam logic [STATE_LEN-1:0] F_MIX1 = 2'd0;
  localparam logic [STATE_LEN-1:0] F_MIX2 = 2'd1;
  localparam logic [STATE_LEN-1:0] F_MIX3 = 2'd2;

  localparam logic [STATE_LEN-1:0] B_MIX1 = 2'd0;
  localparam logic [STATE_LEN-1:0] B_MIX2 = 2'd1;
  localparam logic [STATE_LEN-1:0] B_MIX3 = 2'd2;

  typedef enum logic [3:0] {
    MS_IDLE,
    MS_ZG,
    MS_FWD,
    MS_FGAP,
    MS_WAITB,
    MS_LOADB,
    MS_BWD,
    MS_BGAP,
    MS_UPD,
    MS_DONE
  } ms_state_e;

endpackage

// File: rtl/mix_train_sched_watchdog.sv
// -----------------------------------------------------------------------------
// sched_watchdog
//   Cycle counter guarding one run phase of the training sequencer.
//   Ports:
//     clk, rst_n  clock / asynchronous active-low reset
//     clear       restart the count (phase entry); wins over enable
//     enable      count this cycle (a run line is high)
//     expired     high in the TIMEOUT-th enabled cycle of the current phase
// -----------------------------------------------------------------------------
module sched_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state is written with <= only, so every flop in the
  // design samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // The count holds k-1 during the k-th run cycle, so this fires on the
  // TIMEOUT-th cycle and the owner leaves the phase at that edge.
  assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mix_train_sched.sv
// -----------------------------------------------------------------------------
// mix_train_sched
//   Training-step sequencer for mix_block. One step runs MIX1..MIX3 forward,
//   waits for the upstream gradient, then runs MIX3..MIX1 backward. Every
//   BATCH steps an optimizer update follows, and the next step starts by
//   clearing the gradients.
//   Ports:
//     clk, rst_n             clock / asynchronous active-low reset
//     start                  request one step (sampled in IDLE only)
//     bwd_go                 upstream gradient ready (pulse, latched while busy)
//     valid_*                phase completion from mix_block
//     run_forward/backward   phase run lines to mix_block
//     load_backward          one-cycle pulse ahead of the backward pass
//     update, zero_grad      optimizer / gradient-clear run lines
//     state_forward/backward layer selectors (held while their run is high)
//     busy, done             step in progress / one-cycle end-of-step pulse
//     err_timeout            sticky: some phase exceeded TIMEOUT cycles
//     step_cnt               steps completed since the last update
// -----------------------------------------------------------------------------
module mix_train_sched
  import mix_train_sched_pkg::*;
#(
  parameter int BATCH   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bwd_go,
  input  logic                 valid_forward,
  input  logic                 valid_backward,
  input  logic                 valid_update,
  input  logic                 valid_zero_grad,
  output logic                 run_forward,
  output logic                 run_backward,
  output logic                 load_backward,
  output logic                 update,
  output logic                 zero_grad,
  output logic [STATE_LEN-1:0] state_forward,
  output logic [STATE_LEN-1:0] state_backward,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic [CNT_W-1:0]     step_cnt
);

  ms_state_e            state_q, state_d;
  logic                 zg_pending_q;
  logic                 bwd_latch_q;
  logic                 abort_done_q;
  logic                 err_q;
  logic [STATE_LEN-1:0] sf_q, sb_q;
  logic [CNT_W-1:0]     step_q;

  logic wd_expired;
  logic run_any;
  logic bwd_seen;
  logic last_step;
  logic in_busy;

  // A pulse arriving in the very cycle we check is as good as a latched one.
  assign bwd_seen  = bwd_latch_q | bwd_go;
  assign last_step = (step_q == CNT_W'(BATCH - 1));

  // ---------------------------------------------------------------------------
  // Next state and decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    run_forward   = 1'b0;
    run_backward  = 1'b0;
    load_backward = 1'b0;
    update        = 1'b0;
    zero_grad     = 1'b0;
    in_busy       = 1'b1;

    unique case (state_q)
      MS_IDLE: begin
        in_busy = 1'b0;
        if (start) state_d = zg_pending_q ? MS_ZG : MS_FWD;
      end
      MS_ZG: begin
        zero_grad = 1'b1;
        if (valid_zero_grad) state_d = MS_FWD;
      end
      MS_FWD: begin
        run_forward = 1'b1;
        if (valid_forward) state_d = MS_FGAP;
      end
      MS_FGAP: begin
        if (sf_q != F_MIX3)  state_d = MS_FWD;
        else if (bwd_seen)   state_d = MS_LOADB;
        else                 state_d = MS_WAITB;
      end
      MS_WAITB: begin
        if (bwd_seen) state_d = MS_LOADB;
      end
      MS_LOADB: begin
        load_backward = 1'b1;
        state_d       = MS_BWD;
      end
      MS_BWD: begin
        run_backward = 1'b1;
        if (valid_backward) state_d = MS_BGAP;
      end
      MS_BGAP: begin
        if (sb_q != B_MIX1) state_d = MS_BWD;
        else                state_d = last_step ? MS_UPD : MS_DONE;
      end
      MS_UPD: begin
        update = 1'b1;
        if (valid_update) state_d = MS_DONE;
      end
      MS_DONE: begin
        in_busy = 1'b0;
        state_d = MS_IDLE;
      end
      default: begin
        in_busy = 1'b0;
        state_d = MS_IDLE;
      end
    endcase

    // A stuck phase is abandoned outright; runs drop with the state change.
    if (wd_expired) state_d = MS_IDLE;
  end

  assign run_any = run_forward | run_backward | update | zero_grad;

  sched_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_d != state_q),
    .enable  (run_any),
    .expired (wd_expired)
  );

  // ---------------------------------------------------------------------------
  // State, phase counters and bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MS_IDLE;
      zg_pending_q <= 1'b1;
      bwd_latch_q  <= 1'b0;
      abort_done_q <= 1'b0;
      err_q        <= 1'b0;
      sf_q         <= F_MIX1;
      sb_q         <= B_MIX3;
      step_q       <= '0;
    end else begin
      state_q      <= state_d;
      abort_done_q <= wd_expired;
      if (wd_expired) err_q <= 1'b1;

      // Consumed on the way into LOADB; a new pulse in that cycle is dropped.
      if (state_d == MS_LOADB || wd_expired) bwd_latch_q <= 1'b0;
      else if (in_busy && bwd_go)            bwd_latch_q <= 1'b1;

      // Selectors only move in cycles whose run line is low (IDLE, gaps,
      // LOADB), so mix_block never sees them change under an active run.
      if (state_q == MS_IDLE && start)                 sf_q <= F_MIX1;
      else if (state_q == MS_FGAP && sf_q != F_MIX3)   sf_q <= sf_q + STATE_LEN'(1);

      if (state_q == MS_LOADB)                         sb_q <= B_MIX3;
      else if (state_q == MS_BGAP && sb_q != B_MIX1)   sb_q <= sb_q - STATE_LEN'(1);

      if (state_q == MS_ZG && state_d == MS_FWD)       zg_pending_q <= 1'b0;
      else if (state_q == MS_UPD && state_d == MS_DONE) zg_pending_q <= 1'b1;

      // The batch-closing step goes straight to UPD without counting, so
      // step_cnt stays within 0..BATCH-1.
      if (state_q == MS_BGAP && state_d == MS_DONE)     step_q <= step_q + CNT_W'(1);
      else if (state_q == MS_UPD && state_d == MS_DONE) step_q <= '0;
    end
  end

  assign state_forward  = sf_q;
  assign state_backward = sb_q;
  assign busy           = in_busy;
  assign done           = (state_q == MS_DONE) | abort_done_q;
  assign err_timeout    = err_q;
  assign step_cnt       = step_q;

endmodule

// File: tb/tb_mix_train_sched.sv
// -----------------------------------------------------------------------------
// tb_mix_train_sched
//   Directed bench for mix_train_sched (BATCH=2, TIMEOUT=16). A small
//   mix_block model answers each run line with a valid in its 5th cycle; a
//   monitor records the phase order as a trace string and checks run
//   exclusivity and selector stability every cycle.
// -----------------------------------------------------------------------------
module tb_mix_train_sched;
  import mix_train_sched_pkg::*;

  localparam int BATCH   = 2;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 bwd_go;
  logic                 valid_forward;
  logic                 valid_backward;
  logic                 valid_update;
  logic                 valid_zero_grad;
  logic                 run_forward;
  logic                 run_backward;
  logic                 load_backward;
  logic                 update;
  logic                 zero_grad;
  logic [STATE_LEN-1:0] state_forward;
  logic [STATE_LEN-1:0] state_backward;
  logic                 busy;
  logic                 done;
  logic                 err_timeout;
  logic [CNT_W-1:0]     step_cnt;

  int    checks = 0;
  int    passed = 0;
  string trace  = "";
  bit    hold_bwd = 1'b0;

  mix_train_sched #(
    .BATCH   (BATCH),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .bwd_go          (bwd_go),
    .valid_forward   (valid_forward),
    .valid_backward  (valid_backward),
    .valid_update    (valid_update),
    .valid_zero_grad (valid_zero_grad),
    .run_forward     (run_forward),
    .run_backward    (run_backward),
    .load_backward   (load_backward),
    .update          (update),
    .zero_grad       (zero_grad),
    .state_forward   (state_forward),
    .state_backward  (state_backward),
    .busy            (busy),
    .done            (done),
    .err_timeout     (err_timeout),
    .step_cnt        (step_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) passed++;
    else $error("FAIL %s: observed=\"%s\" expected=\"%s\"", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check("done_within_budget", 32'(done), 32'd1);
  endtask

  task automatic wait_bwd(input logic [STATE_LEN-1:0] sel, input int max);
    int n;
    n = 0;
    while (!(run_backward === 1'b1 && state_backward === sel) && n < max) begin
      tick();
      n++;
    end
    check("reach_backward_phase", 32'(run_backward), 32'd1);
  endtask

  // One step from IDLE/DONE: start pulse, bwd_go in cycle bwd_at, then done.
  task automatic do_step(input int bwd_at);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (bwd_at - 1) tick();
    bwd_go = 1'b1;
    tick();
    bwd_go = 1'b0;
    wait_done(200);
  endtask

  // mix_block model: valid in the 5th cycle of each run line.
  initial begin
    int cf, cb, cu, cz;
    cf = 0; cb = 0; cu = 0; cz = 0;
    valid_forward = 1'b0; valid_backward = 1'b0;
    valid_update = 1'b0;  valid_zero_grad = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cf = run_forward  ? cf + 1 : 0;
      cb = run_backward ? cb + 1 : 0;
      cu = update       ? cu + 1 : 0;
      cz = zero_grad    ? cz + 1 : 0;
      valid_forward   = (cf == 5);
      valid_backward  = (cb == 5) && !hold_bwd;
      valid_update    = (cu == 5);
      valid_zero_grad = (cz == 5);
    end
  end

  // Monitor: phase-order trace plus per-cycle exclusivity/stability check.
  initial begin
    logic p_rf, p_rb, p_up, p_zg, p_lb, p_dn, ok;
    logic [STATE_LEN-1:0] p_sf, p_sb;
    p_rf = 0; p_rb = 0; p_up = 0; p_zg = 0; p_lb = 0; p_dn = 0;
    p_sf = F_MIX1; p_sb = B_MIX3;
    forever begin
      @(negedge clk);
      ok = $onehot0({run_forward, run_backward, update, zero_grad})
           && !(run_forward  && p_rf && state_forward  != p_sf)
           && !(run_backward && p_rb && state_backward != p_sb);
      check("runs_exclusive_selectors_stable", 32'(ok), 32'd1);
      if (zero_grad && !p_zg)     trace = {trace, "Z"};
      if (run_forward && !p_rf)   trace = {trace, $sformatf("F%0d", state_forward + 1)};
      if (load_backward && !p_lb) trace = {trace, "L"};
      if (run_backward && !p_rb)  trace = {trace, $sformatf("B%0d", state_backward + 1)};
      if (update && !p_up)        trace = {trace, "U"};
      if (done && !p_dn)          trace = {trace, "D"};
      p_rf = run_forward; p_rb = run_backward; p_up = update; p_zg = zero_grad;
      p_lb = load_backward; p_dn = done; p_sf = state_forward; p_sb = state_backward;
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; bwd_go = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_run_forward",   32'(run_forward),    32'd0);
    check("rst_run_backward",  32'(run_backward),   32'd0);
    check("rst_load_backward", 32'(load_backward),  32'd0);
    check("rst_update",        32'(update),         32'd0);
    check("rst_zero_grad",     32'(zero_grad),      32'd0);
    check("rst_state_forward", 32'(state_forward),  32'(F_MIX1));
    check("rst_state_backward",32'(state_backward), 32'(B_MIX3));
    check("rst_busy",          32'(busy),           32'd0);
    check("rst_done",          32'(done),           32'd0);
    check("rst_err_timeout",   32'(err_timeout),    32'd0);
    check("rst_step_cnt",      32'(step_cnt),       32'd0);

    // 1: first step clears gradients, waits for bwd_go at cycle 40
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_zg_after_1_cycle", 32'(zero_grad), 32'd1);
    check("t1_busy",             32'(busy),      32'd1);
    repeat (39) tick();
    check("t1_waitb_busy",       32'(busy),                        32'd1);
    check("t1_waitb_runs_low",   32'(run_forward | run_backward),  32'd0);
    check_str("t1_trace_fwd",    trace, "ZF1F2F3");
    bwd_go = 1'b1;
    tick();
    bwd_go = 1'b0;
    check("t1_loadb_pulse",      32'(load_backward), 32'd1);
    tick();
    check("t1_loadb_one_cycle",  32'(load_backward), 32'd0);
    check("t1_bwd_run",          32'(run_backward),  32'd1);
    check("t1_bwd_sel_b3",       32'(state_backward), 32'(B_MIX3));
    wait_done(100);
    check("t1_done_not_busy",    32'(busy),     32'd0);
    check("t1_step_cnt",         32'(step_cnt), 32'd1);
    tick();
    check("t1_done_one_cycle",   32'(done),     32'd0);
    check_str("t1_trace",        trace, "ZF1F2F3LB3B2B1D");

    // 2: second step closes the batch; third step clears gradients again
    trace = "";
    do_step(40);
    check("t2_step_cnt_cleared", 32'(step_cnt), 32'd0);
    tick();
    check_str("t2_trace",        trace, "F1F2F3LB3B2B1UD");
    trace = "";
    do_step(40);
    check("t2b_step_cnt",        32'(step_cnt), 32'd1);
    tick();
    check_str("t2b_trace",       trace, "ZF1F2F3LB3B2B1D");

    // 3: bwd_go during F_MIX2 is latched; LOADB right after the F3 gap
    trace = "";
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_fwd_after_1_cycle", 32'(run_forward),   32'd1);
    check("t3_sel_f1",            32'(state_forward), 32'(F_MIX1));
    repeat (8) tick();
    check("t3_in_f2",             32'(run_forward),   32'd1);
    check("t3_sel_f2",            32'(state_forward), 32'(F_MIX2));
    bwd_go = 1'b1;
    tick();
    bwd_go = 1'b0;
    repeat (8) tick();
    check("t3_fgap_runs_low",     32'(run_forward),   32'd0);
    check("t3_fgap_sel_f3",       32'(state_forward), 32'(F_MIX3));
    tick();
    check("t3_loadb_no_wait",     32'(load_backward), 32'd1);
    wait_done(100);
    check("t3_step_cnt",          32'(step_cnt), 32'd0);
    tick();
    check_str("t3_trace",         trace, "F1F2F3LB3B2B1UD");

    // 4: start held high -> back-to-back steps, one per done
    trace = "";
    start = 1'b1;
    tick();
    tick();
    bwd_go = 1'b1;
    tick();
    bwd_go = 1'b0;
    wait_done(200);
    check("t4_first_step_cnt",    32'(step_cnt), 32'd1);
    tick();
    tick();
    check("t4_second_step_fwd",   32'(run_forward), 32'd1);
    bwd_go = 1'b1;
    tick();
    bwd_go = 1'b0;
    wait_done(200);
    start = 1'b0;
    check("t4_second_step_cnt",   32'(step_cnt), 32'd0);
    tick();
    check("t4_idle_after",        32'(busy), 32'd0);
    tick();
    check("t4_no_restart",        32'(busy), 32'd0);
    check_str("t4_trace",         trace, "ZF1F2F3LB3B2B1DF1F2F3LB3B2B1UD");

    // 5: valid_backward withheld -> watchdog abort in B_MIX3
    trace = "";
    hold_bwd = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    bwd_go = 1'b1;
    tick();
    bwd_go = 1'b0;
    wait_bwd(B_MIX3, 100);
    repeat (15) tick();
    check("t5_cycle16_run",       32'(run_backward), 32'd1);
    check("t5_cycle16_no_err",    32'(err_timeout),  32'd0);
    tick();
    check("t5_err_set",           32'(err_timeout),  32'd1);
    check("t5_run_dropped",       32'(run_backward), 32'd0);
    check("t5_done_pulse",        32'(done),         32'd1);
    check("t5_idle",              32'(busy),         32'd0);
    tick();
    check("t5_done_cleared",      32'(done),         32'd0);
    check("t5_err_sticky",        32'(err_timeout),  32'd1);
    check_str("t5_trace",         trace, "ZF1F2F3LB3D");
    hold_bwd = 1'b0;

    // 6: asynchronous reset in the middle of B_MIX2
    trace = "";
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_no_zg_first",       32'(run_forward), 32'd1);
    bwd_go = 1'b1;
    tick();
    bwd_go = 1'b0;
    wait_bwd(B_MIX2, 100);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_runs_low",      32'({run_forward, run_backward, update, zero_grad}), 32'd0);
    check("t6_rst_busy",          32'(busy),           32'd0);
    check("t6_rst_err_cleared",   32'(err_timeout),    32'd0);
    check("t6_rst_step_cnt",      32'(step_cnt),       32'd0);
    check("t6_rst_sel_b3",        32'(state_backward), 32'(B_MIX3));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    trace = "";
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_zg_after_reset",    32'(zero_grad), 32'd1);
    bwd_go = 1'b1;
    tick();
    bwd_go = 1'b0;
    wait_done(200);
    check("t6_step_cnt",          32'(step_cnt), 32'd1);
    tick();
    check_str("t6_trace",         trace, "ZF1F2F3LB3B2B1D");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
